trng_sampler: RTL and testbench

Consumer for the ring-oscillator TRNG's raw `random` bit. Synchronizes the asynchronous raw bit, samples it at a fixed divided rate, applies a repetition-count health test, debiases with a von Neumann corrector, and packs the result into WIDTH-bit words. Words go to the bus-side consumer over a valid/ready handshake. Sits between the TRNG cell and the SoC register/FIFO interface.

---
 rtl/trng_sampler_pkg.sv | 14 +
 rtl/trng_rct.sv | 49 ++++
 rtl/trng_sampler.sv | 124 ++++++++++++
 tb/tb_trng_sampler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_sampler_pkg.sv
// Shared types and sizing helpers for the TRNG sampler datapath.
package trng_sampler_pkg;

  typedef enum logic {
    VN_FIRST,
    VN_SECOND
  } vn_state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a run of RCT_CUTOFF identical samples.
module trng_rct
  import trng_sampler_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic samp,
  input  logic raw_bit,
  output logic fail,
  output logic trip
);

  localparam int unsigned   RW     = cnt_width(RCT_CUTOFF);
  localparam logic [RW-1:0] CUTOFF = RW'(RCT_CUTOFF);

  logic [RW-1:0] run;
  logic [RW-1:0] run_next;
  logic          prev;

  // A zero run count marks "no previous sample", so prev needs no valid reset value.
  always_comb begin
    run_next = run;
    if (samp) begin
      if (run != '0 && raw_bit == prev) begin
        run_next = (run == CUTOFF) ? run : run + 1'b1;
      end else begin
        run_next = RW'(1);
      end
    end
  end

  // trip is the same-cycle set pulse, letting the packer discard its word on this edge.
  assign trip = samp && !fail && (run_next == CUTOFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      run  <= '0;
      prev <= 1'b0;
      fail <= 1'b0;
    end else begin
      run <= run_next;
      if (samp) prev <= raw_bit;
      if (trip) fail <= 1'b1;
    end
  end

endmodule

// File: rtl/trng_sampler.sv
// TRNG consumer: sync, divide, health-test, von Neumann debias, pack into words.
module trng_sampler
  import trng_sampler_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SAMPLE_DIV = 8,
  parameter int unsigned RCT_CUTOFF = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail
);

  localparam int unsigned   DW       = cnt_width(SAMPLE_DIV - 1);
  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic          sync1;
  logic          raw_s;
  logic [DW-1:0] div_cnt;
  logic          samp;
  vn_state_t     vn_state;
  vn_state_t     vn_next;
  logic          vn_bit;
  logic          latch;
  logic          emit;
  logic [BW-1:0] bit_cnt;
  logic          trip;
  logic          accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      raw_s <= 1'b0;
    end else begin
      sync1 <= raw_in;
      raw_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= samp ? '0 : div_cnt + 1'b1;
    end
  end

  assign samp = enable && (div_cnt == DIV_LAST);

  trng_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk    (clk),
    .reset  (reset),
    .samp   (samp),
    .raw_bit(raw_s),
    .fail   (health_fail),
    .trip   (trip)
  );

  always_comb begin
    vn_next = vn_state;
    latch   = 1'b0;
    emit    = 1'b0;
    if (!enable) begin
      vn_next = VN_FIRST;
    end else if (samp) begin
      case (vn_state)
        VN_FIRST: begin
          latch   = 1'b1;
          vn_next = VN_SECOND;
        end
        VN_SECOND: begin
          emit    = (raw_s != vn_bit);
          vn_next = VN_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vn_state <= VN_FIRST;
      vn_bit   <= 1'b0;
    end else begin
      vn_state <= vn_next;
      if (latch) vn_bit <= raw_s;
    end
  end

  assign accept = valid && ready;

  // An emitted bit coinciding with acceptance starts the next word rather than being dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      bit_cnt  <= '0;
    end else if (health_fail || trip) begin
      valid   <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      valid <= 1'b0;
      if (emit) begin
        data_out <= {vn_bit, data_out[WIDTH-1:1]};
        bit_cnt  <= BW'(1);
      end else begin
        bit_cnt <= '0;
      end
    end else if (emit && !valid) begin
      data_out <= {vn_bit, data_out[WIDTH-1:1]};
      bit_cnt  <= bit_cnt + 1'b1;
      if (bit_cnt == BIT_LAST) valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler against a sample-level behavioural model.
module tb_trng_sampler;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned C = 8;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         raw_in = 1'b0;
  logic         enable = 1'b1;
  logic         ready  = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         health_fail;

  trng_sampler #(
    .WIDTH     (W),
    .SAMPLE_DIV(D),
    .RCT_CUTOFF(C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .enable     (enable),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          rdy_always = 1'b0;

  // Model state, advanced once per raw sample or handshake edge.
  bit           m_valid, m_fail, m_have_half, m_half, m_prev;
  int unsigned  m_run, m_bits;
  logic [W-1:0] m_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, valid, m_valid);
    check_eq({tag, "_fail"}, health_fail, m_fail);
    if (m_valid) check_eq({tag, "_data"}, data_out, m_word);
  endtask

  task automatic model_reset();
    m_valid = 0; m_fail = 0; m_have_half = 0; m_half = 0; m_prev = 0;
    m_run = 0; m_bits = 0; m_word = '0;
  endtask

  task automatic model_sample(input bit b, input bit hs);
    bit new_fail;
    bit emit;
    bit eb;
    if (m_run != 0 && b == m_prev) begin
      if (m_run < C) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev   = b;
    new_fail = (m_run >= C);
    emit = 0;
    eb   = 0;
    if (m_have_half) begin
      emit = (b != m_half);
      eb   = m_half;
      m_have_half = 0;
    end else begin
      m_half      = b;
      m_have_half = 1;
    end
    if (m_fail || new_fail) begin
      m_fail = 1; m_valid = 0; m_bits = 0;
    end else begin
      if (hs && m_valid) begin m_valid = 0; m_bits = 0; end
      if (emit && !m_valid) begin
        m_word[m_bits] = eb;   // i-th emitted bit lands at bit i of the finished word
        m_bits++;
        if (m_bits == W) m_valid = 1;
      end
    end
  endtask

  task automatic edge_nosamp(input bit r);
    ready = r;
    @(posedge clk);
    #1;
    if (r && m_valid) begin m_valid = 0; m_bits = 0; end
    check_outputs("edge");
  endtask

  task automatic sample(input bit b, input int unsigned hs_edge = 0, input int unsigned pause_at = 0);
    raw_in = b;
    for (int unsigned e = 1; e < D; e++) begin
      edge_nosamp(rdy_always || hs_edge == e);
      if (pause_at == e) begin
        enable = 0;
        m_have_half = 0;
        repeat (10) edge_nosamp(rdy_always);
        enable = 1;
      end
    end
    ready = rdy_always || hs_edge == D;
    @(posedge clk);
    #1;
    model_sample(b, ready);
    check_outputs("samp");
  endtask

  task automatic pair(input bit a, input bit b);
    sample(a);
    sample(b);
  endtask

  task automatic pause(input int unsigned n);
    enable = 0;
    m_have_half = 0;
    repeat (n) edge_nosamp(rdy_always);
    enable = 1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_eq({tag, "_rst_valid"}, valid, 0);
    check_eq({tag, "_rst_data"}, data_out, 0);
    check_eq({tag, "_rst_fail"}, health_fail, 0);
  endtask

  function automatic bit guard(input bit b);
    if (m_run >= C - 2 && b == m_prev) return !b;
    return b;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] held;
    bit a;
    int unsigned hs, pa;

    repeat (3) @(posedge clk);
    #1;
    do_reset("init");

    // Repeated "10" pairs, then alternating "10"/"01", always ready.
    rdy_always = 1;
    for (int i = 0; i < 8; i++) pair(1, 0);
    check_eq("t1_ff_valid", valid, 1);
    check_eq("t1_ff_data", data_out, 8'hFF);
    for (int i = 0; i < 4; i++) begin pair(1, 0); pair(0, 1); end
    check_eq("t1_55_valid", valid, 1);
    check_eq("t1_55_data", data_out, 8'h55);

    // Equal pairs interleaved with unequal ones.
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom_range(0, 1));
      pair(a, a);
      a = 1'($urandom_range(0, 1));
      exp[i] = a;
      pair(a, !a);
    end
    check_eq("t2_valid", valid, 1);
    check_eq("t2_data", data_out, exp);

    // Back-pressure: hold ready low for three word intervals.
    rdy_always = 0;
    for (int i = 0; i < 8; i++) begin a = 1'($urandom_range(0, 1)); pair(a, !a); end
    check_eq("t3_valid", valid, 1);
    held = m_word;
    for (int i = 0; i < 3 * W; i++) begin a = 1'($urandom_range(0, 1)); pair(a, !a); end
    check_eq("t3_hold_valid", valid, 1);
    check_eq("t3_hold_data", data_out, held);
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom_range(0, 1));
      exp[i] = a;
      sample(a, (i == 0) ? 1 : 0);
      sample(!a);
    end
    check_eq("t3_post_valid", valid, 1);
    check_eq("t3_post_data", data_out, exp);
    // Acceptance on the very edge that emits the first bit of the next word.
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom_range(0, 1));
      exp[i] = a;
      sample(a);
      sample(!a, (i == 0) ? D : 0);
    end
    check_eq("t3_same_valid", valid, 1);
    check_eq("t3_same_data", data_out, exp);

    // Stuck-at-0 from reset.
    do_reset("t4a");
    rdy_always = 1;
    for (int i = 1; i <= 10; i++) begin
      sample(0);
      if (i == 7) check_eq("t4_rct7", health_fail, 0);
      if (i == 8) check_eq("t4_rct8", health_fail, 1);
    end
    check_eq("t4_novalid", valid, 0);
    do_reset("t4b");
    for (int i = 0; i < 8; i++) pair(1, 0);
    check_eq("t4_resume", data_out, 8'hFF);

    // Stuck-at-0 while a completed word is waiting: the word is discarded.
    do_reset("t4c");
    rdy_always = 0;
    for (int i = 0; i < 8; i++) pair(1, 0);
    for (int i = 1; i <= 9; i++) begin
      sample(0);
      if (i == 6) check_eq("t4_wait_valid", valid, 1);
      if (i == 7) begin
        check_eq("t4_drop_fail", health_fail, 1);
        check_eq("t4_drop_valid", valid, 0);
      end
    end

    // Enable dropped with a half pair latched.
    do_reset("t5");
    for (int i = 0; i < 3; i++) pair(1, 0);
    sample(1);
    pause(10);
    for (int i = 0; i < 5; i++) pair(1, 0);
    check_eq("t5_valid", valid, 1);
    check_eq("t5_data", data_out, 8'hFF);

    // Reset with a partial word, then reset while valid.
    do_reset("t6a");
    for (int i = 0; i < 5; i++) pair(1, 0);
    do_reset("t6b");
    for (int i = 0; i < 4; i++) begin pair(0, 1); pair(1, 0); end
    check_eq("t6_valid", valid, 1);
    check_eq("t6_data", data_out, 8'hAA);
    do_reset("t6c");
    for (int i = 0; i < 8; i++) pair(1, 0);
    check_eq("t6_fresh", data_out, 8'hFF);

    // Randomized traffic, ready modes, handshakes and pauses.
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) rdy_always = 1'($urandom_range(0, 1));
      a  = guard(1'($urandom_range(0, 1)));
      hs = (!rdy_always && $urandom_range(0, 3) == 0) ? $urandom_range(1, D) : 0;
      pa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, D - 1) : 0;
      sample(a, hs, pa);
      if ($urandom_range(0, 19) == 0) pause($urandom_range(1, 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
